// File: rtl/tabla_sweep_ctrl.sv
// Sweeps a combinational truth-table block through every input code in ascending
// order, captures its output column and scores it against a golden column.
module tabla_sweep_ctrl #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int unsigned NCODE = 2**N_IN;
    localparam int unsigned IDX_W = N_IN;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [NCODE-1:0]   exp_q;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               mismatch;

    // Case-inequality so an unknown output from the table block scores as an error.
    always_comb begin
        mismatch = 1'b0;
        mismatch = (dut_out !== exp_q[idx]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            exp_q         <= '0;
            idx           <= '0;
            cnt           <= '0;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            captured      <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q         <= expected;
                        captured      <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        pass          <= 1'b0;
                        idx           <= '0;
                        dut_in        <= '0;
                        busy          <= 1'b1;
                        cnt           <= CNT_W'(SETTLE - 1);
                        state         <= APPLY;
                    end
                end
                APPLY: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    captured[idx] <= dut_out;
                    if (mismatch) begin
                        err_count <= err_count + ERR_W'(1);
                        if (err_count == '0) begin
                            first_err_idx <= idx;
                        end
                    end
                    // Last code ends the sweep instead of wrapping the index.
                    if (idx == '1) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        idx    <= idx + IDX_W'(1);
                        dut_in <= idx + IDX_W'(1);
                        cnt    <= CNT_W'(SETTLE - 1);
                        state  <= APPLY;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tabla_sweep_ctrl.sv
// Bench for tabla_sweep_ctrl: a 3-input and a 4-input instance, each driven by a
// truth-table model of the TABLA block, checked against vectors and a reference model.
module tb_tabla_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_drv;
    int          sel;
    logic [15:0] tt_drv;
    logic [15:0] exp_drv;

    logic        start3, start4, out3, out4;
    logic [7:0]  exp3, cap3;
    logic [15:0] exp4, cap4;
    logic [2:0]  din3, first3;
    logic [3:0]  din4, first4, err3;
    logic [4:0]  err4;
    logic        busy3, busy4, done3, done4, pass3, pass4;

    logic [3:0]  din_v, first_v;
    logic [4:0]  err_v;
    logic [15:0] cap_v;
    logic        busy_v, done_v, pass_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign start3 = start_drv && (sel == 0);
    assign start4 = start_drv && (sel == 1);
    assign exp3   = exp_drv[7:0];
    assign exp4   = exp_drv;
    assign out3   = tt_drv[din3];
    assign out4   = tt_drv[din4];

    assign din_v   = (sel == 1) ? din4   : {1'b0, din3};
    assign first_v = (sel == 1) ? first4 : {1'b0, first3};
    assign err_v   = (sel == 1) ? err4   : {1'b0, err3};
    assign cap_v   = (sel == 1) ? cap4   : {8'h00, cap3};
    assign busy_v  = (sel == 1) ? busy4  : busy3;
    assign done_v  = (sel == 1) ? done4  : done3;
    assign pass_v  = (sel == 1) ? pass4  : pass3;

    tabla_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u3 (
        .clk(clk), .reset(reset), .start(start3), .expected(exp3), .dut_out(out3),
        .dut_in(din3), .busy(busy3), .done(done3), .pass(pass3), .captured(cap3),
        .err_count(err3), .first_err_idx(first3)
    );

    tabla_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u4 (
        .clk(clk), .reset(reset), .start(start4), .expected(exp4), .dut_out(out4),
        .dut_in(din4), .busy(busy4), .done(done4), .pass(pass4), .captured(cap4),
        .err_count(err4), .first_err_idx(first4)
    );

    typedef struct {
        int          sel;
        logic [15:0] tt;
        logic [15:0] ex;
        logic [15:0] cap;
        int          err;
        int          first;
        bit          ps;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (sel=%0d, t=%0t)", nm, act, req, sel, $time);
        end
    endtask

    function automatic int ncodes();
        return (sel == 1) ? 16 : 8;
    endfunction

    // Reference: output column is the table itself; errors are the differing bits.
    function automatic void ref_model(input logic [15:0] tt, input logic [15:0] ex,
                                      output logic [15:0] cap, output int errs,
                                      output int first, output bit ps);
        logic [15:0] mask;
        logic [15:0] diff;
        mask  = (sel == 1) ? 16'hFFFF : 16'h00FF;
        cap   = tt & mask;
        diff  = (tt ^ ex) & mask;
        errs  = $countones(diff);
        first = 0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) first = i;
        end
        ps = (errs == 0);
    endfunction

    task automatic kick(input logic [15:0] tt, input logic [15:0] ex);
        @(negedge clk);
        tt_drv    = tt;
        exp_drv   = ex;
        start_drv = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1 of a sweep; returns in the done cycle (or after a bound).
    task automatic track(input int restart_at, input bit hold, output int dc, output bit ok);
        int c;
        c  = 1;
        ok = 1'b1;
        dc = -1;
        exp_drv = ~exp_drv;
        while (c <= 2 * ncodes() + 10) begin
            if (done_v === 1'b1) begin
                dc = c;
                break;
            end
            if (din_v !== 4'((c - 1) / 2) || busy_v !== 1'b1) ok = 1'b0;
            start_drv = hold || (c == restart_at);
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic results(input logic [15:0] cap, input int errs, input int first,
                           input bit ps, input int dc, input bit ok);
        chk("done_cycle", 32'(dc), 32'(2 * ncodes() + 1));
        chk("din_busy_seq", 32'(ok), 32'd1);
        chk("busy_at_done", 32'(busy_v), 32'd0);
        chk("pass", 32'(pass_v), 32'(ps));
        chk("captured", 32'(cap_v), 32'(cap));
        chk("err_count", 32'(err_v), 32'(errs));
        chk("first_err_idx", 32'(first_v), 32'(first));
    endtask

    task automatic post(input logic [15:0] cap);
        @(posedge clk);
        #1;
        chk("done_single_pulse", 32'(done_v), 32'd0);
        chk("busy_idle", 32'(busy_v), 32'd0);
        chk("captured_held", 32'(cap_v), 32'(cap));
    endtask

    initial begin
        logic [15:0] tt, ex, rcap;
        int          rerr, rfirst, dc, pulses;
        bit          rps, ok;

        tbl[0] = '{0, 16'h0080, 16'h0080, 16'h0080, 0, 0, 1'b1};
        tbl[1] = '{0, 16'h0080, 16'h00A0, 16'h0080, 1, 5, 1'b0};
        tbl[2] = '{0, 16'h00FE, 16'h00FE, 16'h00FE, 0, 0, 1'b1};
        tbl[3] = '{0, 16'h00FE, 16'h0000, 16'h00FE, 7, 1, 1'b0};
        tbl[4] = '{0, 16'h0096, 16'h0069, 16'h0096, 8, 0, 1'b0};
        tbl[5] = '{0, 16'h0001, 16'h0081, 16'h0001, 1, 7, 1'b0};
        tbl[6] = '{1, 16'h6996, 16'h6996, 16'h6996, 0, 0, 1'b1};
        tbl[7] = '{1, 16'h6996, 16'h6997, 16'h6996, 1, 0, 1'b0};
        tbl[8] = '{1, 16'h6996, 16'h0000, 16'h6996, 8, 1, 1'b0};
        tbl[9] = '{1, 16'hFFFF, 16'h0000, 16'hFFFF, 16, 0, 1'b0};

        reset = 1'b1; start_drv = 1'b0; sel = 0; tt_drv = '0; exp_drv = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_din", 32'(din_v), 32'd0);
            chk("rst_busy", 32'(busy_v), 32'd0);
            chk("rst_done", 32'(done_v), 32'd0);
            chk("rst_pass", 32'(pass_v), 32'd0);
            chk("rst_cap", 32'(cap_v), 32'd0);
            chk("rst_err", 32'(err_v), 32'd0);
            chk("rst_first", 32'(first_v), 32'd0);
        end

        // Directed vectors, including an ignored re-start at cycle 10 on entry 6.
        for (int i = 0; i < 10; i++) begin
            sel = tbl[i].sel;
            kick(tbl[i].tt, tbl[i].ex);
            track((i == 6) ? 10 : 0, 1'b0, dc, ok);
            results(tbl[i].cap, tbl[i].err, tbl[i].first, tbl[i].ps, dc, ok);
            post(tbl[i].cap);
        end

        // Reset at cycle 9 aborts the sweep; the next start runs a full sweep.
        sel = 1;
        kick(16'h6996, 16'h6996);
        start_drv = 1'b0;
        for (int c = 1; c < 9; c++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_cap", 32'(cap_v != 16'h0), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_din", 32'(din_v), 32'd0);
        chk("abort_busy", 32'(busy_v), 32'd0);
        chk("abort_cap", 32'(cap_v), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done_v === 1'b1) pulses++;
        end
        chk("abort_no_done", 32'(pulses), 32'd0);
        kick(16'h6996, 16'h6996);
        track(0, 1'b0, dc, ok);
        results(16'h6996, 0, 0, 1'b1, dc, ok);
        post(16'h6996);

        // Start held high: back-to-back sweeps with one idle cycle and refreshed results.
        sel = 0;
        kick(16'h0080, 16'h0080);
        track(0, 1'b1, dc, ok);
        results(16'h0080, 0, 0, 1'b1, dc, ok);
        tt_drv  = 16'h00FE;
        exp_drv = 16'h00FF;
        post(16'h0080);
        @(posedge clk);
        #1;
        chk("b2b_restart_busy", 32'(busy_v), 32'd1);
        chk("b2b_restart_din", 32'(din_v), 32'd0);
        chk("b2b_cleared_cap", 32'(cap_v), 32'd0);
        track(0, 1'b1, dc, ok);
        start_drv = 1'b0;
        results(16'h00FE, 1, 0, 1'b0, dc, ok);
        post(16'h00FE);

        // Random tables against the reference model.
        for (int r = 0; r < 24; r++) begin
            sel = int'($urandom_range(0, 1));
            tt  = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       ex = tt;
                1:       ex = tt ^ (16'h0001 << $urandom_range(0, 15));
                default: ex = 16'($urandom);
            endcase
            ref_model(tt, ex, rcap, rerr, rfirst, rps);
            kick(tt, ex);
            track(int'($urandom_range(0, 12)), 1'b0, dc, ok);
            results(rcap, rerr, rfirst, rps, dc, ok);
            post(rcap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
